// File: rtl/spmv_result_writer_pkg.sv
// Shared definitions for the SpMV result writer: entry layout, lane width and FSM states.
// Build-wide widths fall back to local defaults when the including build does not define them.
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 8
`endif
`ifndef DATA_PRECISION
`define DATA_PRECISION 16
`endif
`ifndef DATA_WIDTH_ADD_STG
`define DATA_WIDTH_ADD_STG (`BITS_ROW_IDX + `DATA_PRECISION + 1)
`endif

package spmv_result_writer_pkg;
    localparam int unsigned ROW_BITS   = `BITS_ROW_IDX;
    localparam int unsigned VAL_BITS   = `DATA_PRECISION;
    localparam int unsigned ENTRY_BITS = `DATA_WIDTH_ADD_STG;
    localparam int unsigned EW         = ROW_BITS + VAL_BITS;

    // Entry layout {row_idx, value, valid}
    localparam int unsigned VALID_BIT  = 0;
    localparam int unsigned VALUE_LSB  = 1;
    localparam int unsigned ROW_LSB    = ENTRY_BITS - ROW_BITS;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_SEND,
        ST_FLUSH,
        ST_DONE
    } state_t;
endpackage

// File: rtl/spmv_result_writer_if.sv
// Accumulator-queue drain port plus packed result write port.
interface spmv_result_writer_if
    import spmv_result_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ENTRY_BITS,
    parameter int unsigned PACK       = 4,
    parameter int unsigned LANE_W     = EW
);
    logic                     q_rd_ready;
    logic [DATA_WIDTH-1:0]    q_data;
    logic                     q_rd_en;
    logic                     wr_valid;
    logic [PACK*LANE_W-1:0]   wr_data;
    logic [PACK-1:0]          wr_mask;
    logic                     wr_ready;

    modport master (
        input  q_rd_ready, q_data, wr_ready,
        output q_rd_en, wr_valid, wr_data, wr_mask
    );

    modport slave (
        output q_rd_ready, q_data, wr_ready,
        input  q_rd_en, wr_valid, wr_data, wr_mask
    );
endinterface

// File: rtl/spmv_result_writer_result_packer.sv
// Lane register array for one output word: loads payloads at lane_ptr, tracks the lane mask.
module result_packer #(
    parameter int unsigned PACK   = 4,
    parameter int unsigned LANE_W = 24,
    localparam int unsigned PTR_W = $clog2(PACK)
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   load,
    input  logic                   clear,
    input  logic [LANE_W-1:0]      din,
    output logic [PACK*LANE_W-1:0] data,
    output logic [PACK-1:0]        mask,
    output logic [PTR_W-1:0]       lane_ptr,
    output logic                   full
);

    // Asserted on the load that fills the last lane
    assign full = load && (lane_ptr == PTR_W'(PACK - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data     <= '0;
            mask     <= '0;
            lane_ptr <= '0;
        end else if (clear) begin
            data     <= '0;
            mask     <= '0;
            lane_ptr <= '0;
        end else if (load) begin
            for (int unsigned k = 0; k < PACK; k++) begin
                if (lane_ptr == PTR_W'(k)) begin
                    data[k*LANE_W +: LANE_W] <= din;
                    mask[k]                  <= 1'b1;
                end
            end
            lane_ptr <= lane_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/spmv_result_writer.sv
// Drains the accumulator output queue, packs valid results into words and
// presents them to result memory; checks row ordering and flags end of stream.
module spmv_result_writer
    import spmv_result_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = ENTRY_BITS,
    parameter int unsigned BITS_ROW_IDX = ROW_BITS,
    parameter int unsigned PACK         = 4,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    en_global,
    input  logic                    data_ended,
    spmv_result_writer_if.master    bus,
    output logic                    done,
    output logic [BITS_ROW_IDX:0]   result_cnt,
    output logic                    order_err
);

    localparam int unsigned LANE_W = DATA_WIDTH - 1;
    localparam int unsigned PTR_W  = $clog2(PACK);
    localparam int unsigned IDLE_W = $clog2(DRAIN_CYCLES + 1);

    state_t                  state, state_nx;
    logic                    ended_r;
    logic [IDLE_W-1:0]       idle_cnt;
    logic                    first_seen;
    logic [BITS_ROW_IDX-1:0] last_row;
    logic [BITS_ROW_IDX-1:0] row_in;
    logic                    pop, load, clear, full, accept, idle_hit;
    logic [PTR_W-1:0]        lane_ptr;

    assign row_in   = bus.q_data[DATA_WIDTH-1 -: BITS_ROW_IDX];
    // Pop is held off during reset so the queue never loses an entry while the writer is cleared
    assign pop      = rst_b && en_global && bus.q_rd_ready && (state == ST_FILL);
    assign load     = pop && bus.q_data[VALID_BIT];
    assign accept   = en_global && bus.wr_ready && ((state == ST_SEND) || (state == ST_FLUSH));
    assign idle_hit = (idle_cnt == IDLE_W'(DRAIN_CYCLES));

    assign bus.q_rd_en  = pop;
    assign bus.wr_valid = (state == ST_SEND) || (state == ST_FLUSH);
    assign done         = (state == ST_DONE);

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        case (state)
            ST_FILL: begin
                if (en_global) begin
                    if (full) begin
                        state_nx = ST_SEND;
                    end else if (idle_hit) begin
                        state_nx = ((lane_ptr != '0) || load) ? ST_FLUSH : ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (accept) begin
                    clear    = 1'b1;
                    state_nx = ST_FILL;
                end
            end
            ST_FLUSH: begin
                if (accept) begin
                    clear    = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= ST_FILL;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ended_r    <= 1'b0;
            idle_cnt   <= '0;
            result_cnt <= '0;
            order_err  <= 1'b0;
            first_seen <= 1'b0;
            last_row   <= '0;
        end else if (en_global) begin
            if (data_ended) ended_r <= 1'b1;
            if (state == ST_FILL) begin
                if (bus.q_rd_ready)            idle_cnt <= '0;
                else if (ended_r && !idle_hit) idle_cnt <= idle_cnt + 1'b1;
            end
            if (load) begin
                if (result_cnt != '1) result_cnt <= result_cnt + 1'b1;
                if (first_seen && (row_in <= last_row)) order_err <= 1'b1;
                first_seen <= 1'b1;
                last_row   <= row_in;
            end
        end
    end

    result_packer #(
        .PACK   (PACK),
        .LANE_W (LANE_W)
    ) u_packer (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (load),
        .clear    (clear),
        .din      (bus.q_data[DATA_WIDTH-1:VALUE_LSB]),
        .data     (bus.wr_data),
        .mask     (bus.wr_mask),
        .lane_ptr (lane_ptr),
        .full     (full)
    );

endmodule

// File: tb/tb_spmv_result_writer.sv
// Randomized bench for spmv_result_writer against a queue-based reference model.
module tb_spmv_result_writer;

    localparam int unsigned DW = 25;
    localparam int unsigned RB = 8;
    localparam int unsigned LW = 24;
    localparam int unsigned PK = 4;
    localparam int unsigned DR = 4;

    logic          clk = 1'b0;
    logic          rst_b, en_global, data_ended, done, order_err;
    logic [RB:0]   result_cnt;

    always #5 clk = ~clk;

    spmv_result_writer_if #(.DATA_WIDTH(DW), .PACK(PK), .LANE_W(LW)) bus();

    spmv_result_writer #(
        .DATA_WIDTH   (DW),
        .BITS_ROW_IDX (RB),
        .PACK         (PK),
        .DRAIN_CYCLES (DR)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .en_global  (en_global),
        .data_ended (data_ended),
        .bus        (bus),
        .done       (done),
        .result_cnt (result_cnt),
        .order_err  (order_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Upstream queue and stimulus knobs
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] pend[$];
    bit trickle, rnd_ready, rnd_en, drive_end;
    int ready_low;

    // Reference model: list of results in the open word plus the presented word
    logic [LW-1:0]    m_lanes[$];
    logic [PK*LW-1:0] m_word;
    logic [PK-1:0]    m_mask;
    bit m_present, m_flush, m_done, m_ended, m_seen, m_err;
    int m_idle, m_cnt, m_last_row;

    function automatic logic [DW-1:0] mk_entry(input int row, input bit v);
        logic [RB-1:0] r;
        logic [15:0]   val;
        r   = row[RB-1:0];
        val = 16'($urandom);
        return {r, val, v};
    endfunction

    task automatic model_close(input bit flush);
        m_word = '0;
        m_mask = '0;
        for (int k = 0; k < m_lanes.size(); k++) begin
            m_word[k*LW +: LW] = m_lanes[k];
            m_mask[k] = 1'b1;
        end
        m_lanes.delete();
        m_present = 1'b1;
        m_flush   = flush;
    endtask

    task automatic model_reset();
        m_lanes.delete();
        m_word = '0; m_mask = '0;
        m_present = 0; m_flush = 0; m_done = 0; m_ended = 0; m_seen = 0; m_err = 0;
        m_idle = 0; m_cnt = 0; m_last_row = 0;
    endtask

    // One clock cycle, entered and left at a falling edge
    task automatic cycle();
        bit exp_pop, dut_pop, old_ended, filled;
        logic [DW-1:0] e;
        if (pend.size() > 0) begin
            if (!trickle) while (pend.size() > 0) fifo.push_back(pend.pop_front());
            else if ($urandom_range(0, 1) == 1) fifo.push_back(pend.pop_front());
        end
        en_global    = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.wr_ready = (ready_low > 0) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        if (ready_low > 0) ready_low--;
        data_ended     = drive_end;
        bus.q_rd_ready = (fifo.size() != 0);
        bus.q_data     = (fifo.size() != 0) ? fifo[0] : '0;
        #1;
        exp_pop = en_global && (fifo.size() != 0) && !m_present && !m_done;
        check("q_rd_en", bus.q_rd_en, exp_pop);
        check("wr_valid", bus.wr_valid, m_present);
        check("done", done, m_done);
        check("result_cnt", result_cnt, m_cnt);
        check("order_err", order_err, m_err);
        if (m_present) begin
            check("wr_data", bus.wr_data, m_word);
            check("wr_mask", bus.wr_mask, m_mask);
        end
        dut_pop = bus.q_rd_en;
        @(posedge clk);
        if (en_global) begin
            old_ended = m_ended;
            if (data_ended) m_ended = 1;
            if (m_done) begin
            end else if (m_present) begin
                if (bus.wr_ready) begin
                    m_present = 0;
                    if (m_flush) m_done = 1;
                    m_flush = 0;
                end
            end else begin
                filled = 0;
                if (exp_pop) begin
                    e = fifo[0];
                    if (e[0]) begin
                        if (m_seen && int'(e[DW-1 -: RB]) <= m_last_row) m_err = 1;
                        m_seen = 1;
                        m_last_row = int'(e[DW-1 -: RB]);
                        if (m_cnt < (1 << (RB + 1)) - 1) m_cnt++;
                        m_lanes.push_back(e[DW-1:1]);
                        if (m_lanes.size() == PK) begin
                            model_close(0);
                            filled = 1;
                        end
                    end
                end
                if (!filled && m_idle == DR) begin
                    if (m_lanes.size() > 0) model_close(1);
                    else m_done = 1;
                end
                if (fifo.size() != 0) m_idle = 0;
                else if (old_ended && m_idle < DR) m_idle++;
            end
        end
        if (dut_pop && fifo.size() != 0) void'(fifo.pop_front());
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && !m_done; i++) cycle();
        check("done_reached", done, 1'b1);
    endtask

    task automatic do_reset(input bit keep_fifo);
        rst_b = 1'b0;
        #1;
        check("rst_q_rd_en", bus.q_rd_en, 1'b0);
        check("rst_wr_valid", bus.wr_valid, 1'b0);
        check("rst_wr_data", bus.wr_data, '0);
        check("rst_wr_mask", bus.wr_mask, '0);
        check("rst_done", done, 1'b0);
        check("rst_result_cnt", result_cnt, '0);
        check("rst_order_err", order_err, 1'b0);
        model_reset();
        if (!keep_fifo) begin
            fifo.delete();
            pend.delete();
        end
        trickle = 0; rnd_ready = 0; rnd_en = 0; drive_end = 0; ready_low = 0;
        bus.q_rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        int row;
        rst_b = 1'b0; en_global = 1'b0; data_ended = 1'b0;
        bus.wr_ready = 1'b0; bus.q_rd_ready = 1'b0; bus.q_data = '0;
        @(negedge clk);

        // Eight in-order rows, sink always ready
        do_reset(0);
        for (int r = 1; r <= 8; r++) pend.push_back(mk_entry(r, 1));
        run(14);
        check("s1_cnt", result_cnt, 9'd8);
        check("s1_err", order_err, 1'b0);

        // Partial word flushed after drain
        do_reset(0);
        pend.push_back(mk_entry(3, 1));
        pend.push_back(mk_entry(5, 1));
        drive_end = 1;
        run_until_done(40);
        check("s2_cnt", result_cnt, 9'd2);

        // Invalid entries interleaved
        do_reset(0);
        pend.push_back(mk_entry(9, 0));
        pend.push_back(mk_entry(2, 1));
        pend.push_back(mk_entry(1, 0));
        pend.push_back(mk_entry(4, 1));
        pend.push_back(mk_entry(0, 0));
        pend.push_back(mk_entry(0, 0));
        pend.push_back(mk_entry(6, 1));
        pend.push_back(mk_entry(3, 0));
        pend.push_back(mk_entry(8, 1));
        run(16);
        check("s3_cnt", result_cnt, 9'd4);
        check("s3_fifo_empty", fifo.size(), 0);

        // Back-pressure on a full word
        do_reset(0);
        for (int r = 1; r <= 8; r++) pend.push_back(mk_entry(r * 2, 1));
        ready_low = 16;
        run(30);
        check("s4_cnt", result_cnt, 9'd8);

        // Out-of-order rows
        do_reset(0);
        pend.push_back(mk_entry(7, 1));
        pend.push_back(mk_entry(5, 1));
        run(4);
        check("s5_err", order_err, 1'b1);
        drive_end = 1;
        run_until_done(30);

        // Reset with two lanes filled; remaining entries form a fresh word
        do_reset(0);
        for (int r = 1; r <= 6; r++) pend.push_back(mk_entry(r, 1));
        run(2);
        check("s6_partial", bus.wr_mask, 4'b0011);
        do_reset(1);
        run(8);
        check("s6_cnt", result_cnt, 9'd4);

        // Random traffic with stalls, enable gaps and order violations
        do_reset(0);
        trickle = 1; rnd_ready = 1; rnd_en = 1;
        row = 1;
        for (int i = 0; i < 60; i++) begin
            pend.push_back(mk_entry(row, ($urandom_range(0, 3) != 0)));
            row += $urandom_range(0, 3);
        end
        for (int i = 0; i < 600 && pend.size() > 0; i++) cycle();
        drive_end = 1;
        run_until_done(800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
